// File: rtl/ahb3lite_led_ctrl.sv
// rtl/ahb3lite_led_ctrl.sv - AHB3-Lite LED register block with atomic set/clear/toggle and blink timer
module ahb3lite_led_ctrl #(
    parameter int          HADDR_SIZE      = 32,
    parameter int          HDATA_SIZE      = 32,
    parameter int          LED_NUM         = 8,
    parameter int          PRESCALER_WIDTH = 24,
    parameter int unsigned PRESCALE_RST    = 999_999
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    output logic [HDATA_SIZE-1:0] HRDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [LED_NUM-1:0]    led_o,
    output logic                  irq_o
);
    localparam logic [2:0] OFS_LED_OUT = 3'd0;
    localparam logic [2:0] OFS_LED_SET = 3'd1;
    localparam logic [2:0] OFS_LED_CLR = 3'd2;
    localparam logic [2:0] OFS_LED_TGL = 3'd3;
    localparam logic [2:0] OFS_BLINK   = 3'd4;
    localparam logic [2:0] OFS_PRESC   = 3'd5;
    localparam logic [2:0] OFS_CTRL    = 3'd6;
    localparam logic [2:0] OFS_STATUS  = 3'd7;

    typedef enum logic [1:0] {ST_OKAY, ST_ERR1, ST_ERR2} resp_state_t;

    resp_state_t                state, state_nxt;
    logic                       accept, bad_xfer;
    logic                       dp_valid, dp_write;
    logic [2:0]                 dp_ofs;
    logic                       wr_en, w1c;
    logic [LED_NUM-1:0]         led_out, blink_mask, led_bus, wdata_led;
    logic [PRESCALER_WIDTH-1:0] prescale, counter;
    logic [1:0]                 ctrl;
    logic                       expired, expiry;
    logic [HDATA_SIZE-1:0]      rdata;
    logic                       unused_ok;

    // The first error cycle stalls the bus, so no new address phase is taken then.
    assign accept   = HSEL & HREADY & HTRANS[1] & (state != ST_ERR1);
    assign bad_xfer = (HWRITE & (HSIZE != 3'b010)) |
                      ((HSIZE == 3'b010) & (HADDR[1:0] != 2'b00));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= ST_OKAY;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = ST_OKAY;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        case (state)
            ST_ERR1: begin
                state_nxt = ST_ERR2;
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            ST_ERR2: begin
                HRESP = 1'b1;
                if (accept && bad_xfer) state_nxt = ST_ERR1;
            end
            default: begin
                if (accept && bad_xfer) state_nxt = ST_ERR1;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_ofs   <= '0;
        end else begin
            dp_valid <= accept & ~bad_xfer;
            if (accept) begin
                dp_write <= HWRITE;
                dp_ofs   <= HADDR[4:2];
            end
        end
    end

    assign wr_en     = dp_valid & dp_write;
    assign wdata_led = HWDATA[LED_NUM-1:0];
    assign w1c       = wr_en & (dp_ofs == OFS_STATUS) & HWDATA[0];
    assign expiry    = ctrl[0] & (counter == '0);

    always_comb begin
        led_bus = led_out;
        if (wr_en) begin
            case (dp_ofs)
                OFS_LED_OUT: led_bus = wdata_led;
                OFS_LED_SET: led_bus = led_out | wdata_led;
                OFS_LED_CLR: led_bus = led_out & ~wdata_led;
                OFS_LED_TGL: led_bus = led_out ^ wdata_led;
                default:     led_bus = led_out;
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            led_out    <= '0;
            blink_mask <= '0;
            prescale   <= PRESCALER_WIDTH'(PRESCALE_RST);
            counter    <= PRESCALER_WIDTH'(PRESCALE_RST);
            ctrl       <= '0;
            expired    <= 1'b0;
        end else begin
            // Bus result first, blink toggle layered on top; expiry beats a W1C.
            led_out <= led_bus ^ (expiry ? blink_mask : '0);
            expired <= expiry | (expired & ~w1c);
            if (wr_en && dp_ofs == OFS_BLINK) blink_mask <= wdata_led;
            if (wr_en && dp_ofs == OFS_CTRL)  ctrl       <= HWDATA[1:0];
            if (wr_en && dp_ofs == OFS_PRESC) begin
                prescale <= HWDATA[PRESCALER_WIDTH-1:0];
                counter  <= HWDATA[PRESCALER_WIDTH-1:0];
            end else if (!ctrl[0] || counter == '0) begin
                counter <= prescale;
            end else begin
                counter <= counter - PRESCALER_WIDTH'(1);
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (dp_valid && !dp_write) begin
            case (dp_ofs)
                OFS_LED_OUT: rdata[LED_NUM-1:0]         = led_out;
                OFS_BLINK:   rdata[LED_NUM-1:0]         = blink_mask;
                OFS_PRESC:   rdata[PRESCALER_WIDTH-1:0] = prescale;
                OFS_CTRL:    rdata[1:0]                 = ctrl;
                OFS_STATUS:  rdata[0]                   = expired;
                default:     rdata                      = '0;
            endcase
        end
    end

    assign HRDATA    = rdata;
    assign led_o     = led_out;
    assign irq_o     = expired & ctrl[1];
    assign unused_ok = ^{HBURST, HPROT, HADDR[HADDR_SIZE-1:5], HWDATA};

endmodule

// File: tb/tb_ahb3lite_led_ctrl.sv
// tb/tb_ahb3lite_led_ctrl.sv - self-checking bench for ahb3lite_led_ctrl
module tb_ahb3lite_led_ctrl;
    logic        HCLK, HRESETn, HSEL, HWRITE, HREADY, HREADYOUT, HRESP, irq_o;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic [7:0]  led_o;
    logic        hready_force;

    int errors = 0;
    int checks = 0;

    ahb3lite_led_ctrl dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HTRANS(HTRANS), .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
        .led_o(led_o), .irq_o(irq_o)
    );

    assign HREADY = HREADYOUT | hready_force;

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [7:0]  exp_led;
    } vec_t;

    vec_t vecs[$];

    logic [7:0]  m_led, m_mask;
    logic [23:0] m_pre;
    logic [1:0]  m_ctrl;
    logic        m_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [31:0] a, input logic [2:0] s,
                                input logic [31:0] d, input logic [31:0] rd, input logic e,
                                input logic [7:0] led);
        vec_t v;
        v.wr = wr; v.addr = a; v.size = s; v.wdata = d;
        v.exp_rd = rd; v.exp_err = e; v.exp_led = led;
        return v;
    endfunction

    // Called just after a rising edge; returns just after the edge ending the data phase.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic [1:0] resp, output int waits);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = wr; HSIZE = size;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wd;
        waits = 0;
        resp  = 2'b00;
        @(negedge HCLK);
        resp[1] = HRESP;
        while (!HREADYOUT && waits < 8) begin
            waits++;
            @(negedge HCLK);
        end
        if (!HREADYOUT) begin
            errors++;
            $display("FAIL xfer timeout: HREADYOUT stuck low at addr %h", addr);
        end
        resp[0] = HRESP;
        rd = HRDATA;
        @(posedge HCLK); #1;
    endtask

    task automatic wr32(input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] rd;
        logic [1:0]  resp;
        int          waits;
        xfer(1'b1, addr, 3'b010, wd, rd, resp, waits);
    endtask

    task automatic reset_dut();
        HRESETn = 1'b0; HSEL = 1'b0; HTRANS = 2'b00;
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] ofs);
        case (ofs)
            3'd0:    return {24'd0, m_led};
            3'd4:    return {24'd0, m_mask};
            3'd5:    return {8'd0, m_pre};
            3'd6:    return {30'd0, m_ctrl};
            3'd7:    return {31'd0, m_exp};
            default: return 32'd0;
        endcase
    endfunction

    function automatic void model_write(input logic [2:0] ofs, input logic [31:0] d);
        case (ofs)
            3'd0: m_led  = d[7:0];
            3'd1: m_led  = m_led | d[7:0];
            3'd2: m_led  = m_led & ~d[7:0];
            3'd3: m_led  = m_led ^ d[7:0];
            3'd4: m_mask = d[7:0];
            3'd5: m_pre  = d[23:0];
            3'd6: m_ctrl = d[1:0];
            default: if (d[0]) m_exp = 1'b0;
        endcase
    endfunction

    initial begin
        logic [31:0] rd, addr, wd, exp_rd;
        logic [1:0]  resp, lo;
        logic [2:0]  size, ofs;
        logic        wr, exp_err;
        logic [7:0]  l0, msk, exp_led;
        int          waits, p, r;

        HRESETn = 1'b0; HSEL = 1'b0; HTRANS = 2'b00; HADDR = '0; HWDATA = '0;
        HWRITE = 1'b0; HSIZE = 3'b010; HBURST = 3'b000; HPROT = 4'b0011; hready_force = 1'b0;
        #2;
        chk("rst HREADYOUT", 32'(HREADYOUT), 32'd1);
        chk("rst HRESP", 32'(HRESP), 32'd0);
        chk("rst HRDATA", HRDATA, 32'd0);
        chk("rst led_o", 32'(led_o), 32'd0);
        chk("rst irq_o", 32'(irq_o), 32'd0);
        reset_dut();

        vecs.push_back(mk(1'b0, 32'h00, 3'd2, 32'h0, 32'h0,      1'b0, 8'h00));
        vecs.push_back(mk(1'b0, 32'h04, 3'd2, 32'h0, 32'h0,      1'b0, 8'h00));
        vecs.push_back(mk(1'b0, 32'h08, 3'd2, 32'h0, 32'h0,      1'b0, 8'h00));
        vecs.push_back(mk(1'b0, 32'h0C, 3'd2, 32'h0, 32'h0,      1'b0, 8'h00));
        vecs.push_back(mk(1'b0, 32'h10, 3'd2, 32'h0, 32'h0,      1'b0, 8'h00));
        vecs.push_back(mk(1'b0, 32'h14, 3'd2, 32'h0, 32'h0F423F, 1'b0, 8'h00));
        vecs.push_back(mk(1'b0, 32'h18, 3'd2, 32'h0, 32'h0,      1'b0, 8'h00));
        vecs.push_back(mk(1'b0, 32'h1C, 3'd2, 32'h0, 32'h0,      1'b0, 8'h00));
        vecs.push_back(mk(1'b1, 32'h00, 3'd2, 32'hA5, 32'h0,     1'b0, 8'hA5));
        vecs.push_back(mk(1'b1, 32'h04, 3'd2, 32'h0F, 32'h0,     1'b0, 8'hAF));
        vecs.push_back(mk(1'b1, 32'h08, 3'd2, 32'h81, 32'h0,     1'b0, 8'h2E));
        vecs.push_back(mk(1'b0, 32'h00, 3'd2, 32'h0, 32'h2E,     1'b0, 8'h2E));
        vecs.push_back(mk(1'b1, 32'h10, 3'd2, 32'hFFFFFF3C, 32'h0, 1'b0, 8'h2E));
        vecs.push_back(mk(1'b0, 32'h10, 3'd2, 32'h0, 32'h3C,     1'b0, 8'h2E));
        vecs.push_back(mk(1'b1, 32'h14, 3'd2, 32'hFF000007, 32'h0, 1'b0, 8'h2E));
        vecs.push_back(mk(1'b0, 32'h14, 3'd2, 32'h0, 32'h7,      1'b0, 8'h2E));
        vecs.push_back(mk(1'b1, 32'h18, 3'd2, 32'hFFFFFFFE, 32'h0, 1'b0, 8'h2E));
        vecs.push_back(mk(1'b0, 32'h18, 3'd2, 32'h0, 32'h2,      1'b0, 8'h2E));
        vecs.push_back(mk(1'b1, 32'h18, 3'd2, 32'h0, 32'h0,      1'b0, 8'h2E));
        vecs.push_back(mk(1'b1, 32'h00, 3'd0, 32'hFF, 32'h0,     1'b1, 8'h2E));
        vecs.push_back(mk(1'b0, 32'h02, 3'd2, 32'h0, 32'h0,      1'b1, 8'h2E));
        vecs.push_back(mk(1'b1, 32'h10, 3'd1, 32'h0, 32'h0,      1'b1, 8'h2E));
        vecs.push_back(mk(1'b0, 32'h10, 3'd2, 32'h0, 32'h3C,     1'b0, 8'h2E));
        vecs.push_back(mk(1'b0, 32'h01, 3'd0, 32'h0, 32'h2E,     1'b0, 8'h2E));
        vecs.push_back(mk(1'b0, 32'h04, 3'd2, 32'h0, 32'h0,      1'b0, 8'h2E));
        vecs.push_back(mk(1'b1, 32'h1C, 3'd2, 32'h1, 32'h0,      1'b0, 8'h2E));
        vecs.push_back(mk(1'b0, 32'h1C, 3'd2, 32'h0, 32'h0,      1'b0, 8'h2E));
        vecs.push_back(mk(1'b0, 32'hFFFFFFE0, 3'd2, 32'h0, 32'h2E, 1'b0, 8'h2E));

        foreach (vecs[i]) begin
            xfer(vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wdata, rd, resp, waits);
            chk($sformatf("vec%0d resp", i), 32'(resp), vecs[i].exp_err ? 32'd3 : 32'd0);
            chk($sformatf("vec%0d waits", i), 32'(waits), vecs[i].exp_err ? 32'd1 : 32'd0);
            chk($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d led_o", i), 32'(led_o), 32'(vecs[i].exp_led));
        end

        // Toggle write followed back-to-back by a read of LED_OUT
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0C; HWRITE = 1'b1; HSIZE = 3'b010;
        @(posedge HCLK); #1;
        HWDATA = 32'hFF; HADDR = 32'h00; HWRITE = 1'b0;
        @(negedge HCLK);
        chk("b2b write HREADYOUT", 32'(HREADYOUT), 32'd1);
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        chk("b2b led_o", 32'(led_o), 32'hD1);
        @(negedge HCLK);
        chk("b2b HRDATA", HRDATA, 32'hD1);
        chk("b2b read HREADYOUT", 32'(HREADYOUT), 32'd1);
        chk("b2b HRESP", 32'(HRESP), 32'd0);
        @(posedge HCLK); #1;

        // IDLE and BUSY with HSEL=1 must have no effect
        HSEL = 1'b1; HWRITE = 1'b1; HADDR = 32'h00; HSIZE = 3'b010; HWDATA = 32'h0;
        for (int i = 0; i < 4; i++) begin
            HTRANS = i[0] ? 2'b01 : 2'b00;
            @(negedge HCLK);
            chk($sformatf("idle%0d okay", i), {30'd0, HREADYOUT, HRESP}, 32'h2);
            @(posedge HCLK); #1;
        end
        HSEL = 1'b0; HTRANS = 2'b00;
        chk("idle led_o", 32'(led_o), 32'hD1);

        // A new address phase offered during ERROR cycle 1 is ignored
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h00; HWRITE = 1'b1; HSIZE = 3'b000;
        @(posedge HCLK); #1;
        chk("err1 ready/resp", {30'd0, HREADYOUT, HRESP}, 32'h1);
        hready_force = 1'b1; HSIZE = 3'b010; HWDATA = 32'hFF;
        @(posedge HCLK); #1;
        chk("err2 ready/resp", {30'd0, HREADYOUT, HRESP}, 32'h3);
        hready_force = 1'b0; HSEL = 1'b0; HTRANS = 2'b00;
        @(posedge HCLK); #1;
        chk("after err HRESP", 32'(HRESP), 32'd0);
        chk("after err led_o", 32'(led_o), 32'hD1);

        // Blink timer: PRESCALE=3 gives a 4-cycle period
        wr32(32'h14, 32'd3);
        wr32(32'h10, 32'h01);
        wr32(32'h18, 32'h3);
        for (int k = 0; k < 12; k++) begin
            @(negedge HCLK);
            chk($sformatf("blink k%0d led_o", k), 32'(led_o), (((k / 4) % 2) == 1) ? 32'hD0 : 32'hD1);
            chk($sformatf("blink k%0d irq_o", k), 32'(irq_o), (k >= 4) ? 32'd1 : 32'd0);
            @(posedge HCLK);
        end
        #1;
        wr32(32'h1C, 32'h1);
        chk("w1c clears irq", 32'(irq_o), 32'd0);
        wr32(32'h1C, 32'h1);
        chk("w1c with expiry keeps irq", 32'(irq_o), 32'd1);
        wr32(32'h1C, 32'h1);
        chk("w1c clears again", 32'(irq_o), 32'd0);
        repeat (2) @(posedge HCLK);
        #1;
        chk("next expiry sets irq", 32'(irq_o), 32'd1);
        xfer(1'b0, 32'h1C, 3'd2, 32'h0, rd, resp, waits);
        chk("STATUS read", rd, 32'd1);

        // Random prescale/mask/start value, expected LEDs from period arithmetic
        for (int it = 0; it < 3; it++) begin
            p   = $urandom_range(0, 5);
            msk = 8'($urandom);
            l0  = 8'($urandom);
            wr32(32'h18, 32'h0);
            wr32(32'h14, 32'(p));
            wr32(32'h10, 32'(msk));
            wr32(32'h00, 32'(l0));
            wr32(32'h18, 32'h1);
            for (int k = 0; k < 3 * (p + 1) + 2; k++) begin
                exp_led = l0 ^ ((((k / (p + 1)) % 2) == 1) ? msk : 8'h00);
                @(negedge HCLK);
                chk($sformatf("rblink p%0d k%0d", p, k), 32'(led_o), 32'(exp_led));
                @(posedge HCLK);
            end
            #1;
        end

        // Asynchronous reset in the middle of a timer run
        wr32(32'h18, 32'h0);
        wr32(32'h00, 32'h5A);
        wr32(32'h10, 32'hFF);
        wr32(32'h14, 32'd2);
        wr32(32'h18, 32'h3);
        repeat (4) @(posedge HCLK);
        #3;
        chk("pre-reset led_o", 32'(led_o), 32'hA5);
        chk("pre-reset irq_o", 32'(irq_o), 32'd1);
        HRESETn = 1'b0;
        #1;
        chk("mid-run rst led_o", 32'(led_o), 32'd0);
        chk("mid-run rst irq_o", 32'(irq_o), 32'd0);
        chk("mid-run rst ready/resp", {30'd0, HREADYOUT, HRESP}, 32'h2);
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        xfer(1'b0, 32'h14, 3'd2, 32'h0, rd, resp, waits);
        chk("post-rst PRESCALE", rd, 32'h0F423F);
        chk("post-rst resp", 32'(resp), 32'd0);
        xfer(1'b0, 32'h18, 3'd2, 32'h0, rd, resp, waits);
        chk("post-rst CTRL", rd, 32'd0);

        // Asynchronous reset during ERROR cycle 1
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h00; HWRITE = 1'b1; HSIZE = 3'b000;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        chk("err1 before rst", {30'd0, HREADYOUT, HRESP}, 32'h1);
        HRESETn = 1'b0;
        #1;
        chk("err1 rst ready/resp", {30'd0, HREADYOUT, HRESP}, 32'h2);
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        xfer(1'b1, 32'h00, 3'd2, 32'h3C, rd, resp, waits);
        chk("post-err-rst resp", 32'(resp), 32'd0);
        chk("post-err-rst waits", 32'(waits), 32'd0);
        chk("post-err-rst led_o", 32'(led_o), 32'h3C);

        // Random bus traffic against the register model (timer kept disabled)
        reset_dut();
        m_led = 8'h00; m_mask = 8'h00; m_pre = 24'h0F423F; m_ctrl = 2'b00; m_exp = 1'b0;
        for (int n = 0; n < 150; n++) begin
            ofs  = 3'($urandom_range(0, 7));
            wr   = 1'($urandom_range(0, 1));
            r    = $urandom_range(0, 9);
            size = (r == 0) ? 3'd0 : (r == 1) ? 3'd1 : 3'd2;
            lo   = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            addr = ($urandom & 32'hFFFFFFE0) | {27'd0, ofs, lo};
            wd   = $urandom;
            if (ofs == 3'd6) wd[0] = 1'b0;
            exp_err = (wr && size != 3'd2) || (size == 3'd2 && lo != 2'd0);
            exp_rd  = (!wr && !exp_err) ? model_read(ofs) : 32'd0;
            xfer(wr, addr, size, wd, rd, resp, waits);
            if (wr && !exp_err) model_write(ofs, wd);
            chk($sformatf("rnd%0d resp a=%h", n, addr), 32'(resp), exp_err ? 32'd3 : 32'd0);
            chk($sformatf("rnd%0d rdata a=%h", n, addr), rd, exp_rd);
            chk($sformatf("rnd%0d led_o", n), 32'(led_o), 32'(m_led));
            chk($sformatf("rnd%0d irq_o", n), 32'(irq_o), 32'(m_exp & m_ctrl[1]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
